// File: rtl/game_ctrl.sv
// game_ctrl: lights-puzzle top-level sequencer.
// Button conditioning, game FSM, move/time counters and win detect.
module game_ctrl #(
  parameter int unsigned DB_CYCLES   = 1_000_000,
  parameter int unsigned TICK_DIV    = 100_000_000,
  parameter logic [11:0] WIN_PATTERN = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_go,
  input  logic        btn_move,
  input  logic [11:0] board_out,
  output logic [1:0]  game_status,
  output logic        random,
  output logic [7:0]  move_cnt,
  output logic [9:0]  time_sec,
  output logic        win_flag
);

  localparam int DBW = $clog2(DB_CYCLES);
  localparam int TKW = $clog2(TICK_DIV);
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
  localparam logic [TKW-1:0] TICK_LAST = TKW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    CHOSE_BOARD  = 2'b00,
    GAMING       = 2'b01,
    GAME_INITIAL = 2'b10,
    WINNED       = 2'b11
  } state_t;

  // bit 0 is the go button, bit 1 the move button
  logic [1:0]     raw;
  logic [1:0]     sync1;
  logic [1:0]     sync2;
  logic [1:0]     db;
  logic [1:0]     db_d;
  logic [1:0]     ev;
  logic [DBW-1:0] cnt [2];

  state_t         state;
  logic           init_done;
  logic [TKW-1:0] tick;
  logic           go_ev;
  logic           mv_ev;

  assign raw         = {btn_move, btn_go};
  assign go_ev       = ev[0];
  assign mv_ev       = ev[1];
  assign game_status = state;

  // synchronize, debounce and turn rising debounced levels into pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      db_d  <= '0;
      ev    <= '0;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      db_d  <= db;
      ev    <= db & ~db_d;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          db[i]  <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // game sequencing, counters and registered strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CHOSE_BOARD;
      init_done <= 1'b0;
      tick      <= '0;
      random    <= 1'b0;
      move_cnt  <= '0;
      time_sec  <= '0;
      win_flag  <= 1'b0;
    end else begin
      random <= 1'b0;
      unique case (state)
        CHOSE_BOARD: begin
          if (go_ev) begin
            state     <= GAME_INITIAL;
            init_done <= 1'b0;
            move_cnt  <= '0;
            time_sec  <= '0;
            tick      <= '0;
          end else if (mv_ev) begin
            random <= 1'b1;
          end
        end
        GAME_INITIAL: begin
          move_cnt  <= '0;
          time_sec  <= '0;
          tick      <= '0;
          init_done <= 1'b1;
          if (init_done) state <= GAMING;
        end
        GAMING: begin
          if (tick == TICK_LAST) begin
            tick <= '0;
            if (time_sec != 10'd999) time_sec <= time_sec + 1'b1;
          end else begin
            tick <= tick + 1'b1;
          end
          if (go_ev) begin
            state <= CHOSE_BOARD;
          end else if (mv_ev) begin
            random <= 1'b1;
            if (move_cnt != 8'hFF) move_cnt <= move_cnt + 1'b1;
          end else if (!random && board_out == WIN_PATTERN
                       && move_cnt != 8'd0) begin
            state    <= WINNED;
            win_flag <= 1'b1;
          end
        end
        WINNED: begin
          if (go_ev) begin
            state    <= CHOSE_BOARD;
            win_flag <= 1'b0;
          end
        end
        default: state <= CHOSE_BOARD;
      endcase
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: randomized scenarios for game_ctrl checked
// against a rule-level model of buttons and game flow.
module tb_game_ctrl;

  localparam int DB = 4;
  localparam int TD = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_go = 1'b0;
  logic        btn_move = 1'b0;
  logic [11:0] board_out = 12'hFFF;
  logic [1:0]  game_status;
  logic        random;
  logic [7:0]  move_cnt;
  logic [9:0]  time_sec;
  logic        win_flag;

  int n_cmp = 0;
  int n_bad = 0;

  game_ctrl #(
    .DB_CYCLES(DB),
    .TICK_DIV(TD),
    .WIN_PATTERN(12'h000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_go(btn_go),
    .btn_move(btn_move),
    .board_out(board_out),
    .game_status(game_status),
    .random(random),
    .move_cnt(move_cnt),
    .time_sec(time_sec),
    .win_flag(win_flag)
  );

  always #5 clk = ~clk;

  // reference model: game codes 0 choose, 1 playing, 2 starting, 3 won
  bit [1:0] m_r1, m_r2, m_db, m_dbd, m_ev;
  bit       hist [2][$];
  int       m_st, m_init, m_moves, m_gcyc, m_pulses;
  bit       m_rand;

  always @(posedge clk) begin
    bit go, mv, nr, flip;
    if (rst) begin
      m_r1 = 0; m_r2 = 0; m_db = 0; m_dbd = 0; m_ev = 0;
      hist[0].delete();
      hist[1].delete();
      m_st = 0; m_init = 0; m_moves = 0; m_gcyc = 0; m_rand = 0;
    end else begin
      go = m_ev[0];
      mv = m_ev[1];
      nr = 0;
      case (m_st)
        0: if (go) begin
             m_st = 2; m_init = 0; m_moves = 0; m_gcyc = 0;
           end else if (mv) nr = 1;
        2: begin
             m_init++;
             if (m_init == 2) m_st = 1;
           end
        1: begin
             m_gcyc++;
             if (go) m_st = 0;
             else if (mv) begin
               nr = 1;
               if (m_moves < 255) m_moves++;
             end else if (!m_rand && board_out == 12'h000 && m_moves != 0)
               m_st = 3;
           end
        default: if (go) m_st = 0;
      endcase
      m_rand = nr;
      if (nr) m_pulses++;
      // a level is accepted once the last DB synchronized samples all disagree
      m_ev = m_db & ~m_dbd;
      m_dbd = m_db;
      for (int i = 0; i < 2; i++) begin
        hist[i].push_back(m_r2[i]);
        if (hist[i].size() > DB) void'(hist[i].pop_front());
        if (hist[i].size() == DB) begin
          flip = 1;
          for (int k = 0; k < DB; k++)
            if (hist[i][k] == m_db[i]) flip = 0;
          if (flip) begin
            m_db[i] = ~m_db[i];
            hist[i].delete();
          end
        end
      end
      m_r2 = m_r1;
      m_r1 = {btn_move, btn_go};
    end
  end

  // per-cycle DUT vs model tally, plus random pulse counters
  bit    mon_en = 0;
  bit    rand_q = 0;
  int    mon_bad = 0;
  int    d_pulses = 0;
  int    d_high = 0;
  string mon_msg = "";

  always @(negedge clk) begin
    int es;
    if (mon_en) begin
      es = m_gcyc / TD;
      if (es > 999) es = 999;
      if (random === 1'b1) d_high++;
      if (random === 1'b1 && !rand_q) d_pulses++;
      rand_q = (random === 1'b1);
      if (game_status !== 2'(m_st) || random !== m_rand ||
          move_cnt !== 8'(m_moves) || time_sec !== 10'(es) ||
          win_flag !== (m_st == 3)) begin
        mon_bad++;
        if (mon_bad == 1)
          mon_msg = $sformatf(
            "t=%0t st=%0d/%0d rnd=%0b/%0b mv=%0d/%0d sec=%0d/%0d win=%0b",
            $time, game_status, m_st, random, m_rand, move_cnt, m_moves,
            time_sec, es, win_flag);
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic press(input bit mv, input int hold, input int gap);
    if (mv) btn_move = 1'b1; else btn_go = 1'b1;
    step(hold);
    if (mv) btn_move = 1'b0; else btn_go = 1'b0;
    step(gap);
  endtask

  task automatic wait_status(input logic [1:0] s, input int lim);
    int n;
    n = 0;
    while (game_status !== s && n < lim) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    int n, mb0, p0;
    rst = 1'b1; btn_go = 1'b1; btn_move = 1'b1;
    board_out = 12'hABC;
    step(1);
    mon_en = 1;
    mb0 = mon_bad;
    p0 = d_pulses;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({game_status, random, move_cnt, time_sec, win_flag} !== 22'b0) begin
        n_bad++;
        $display("FAIL reset_outputs[%0d]: got st=%b rnd=%b mv=%0d sec=%0d win=%b want all 0",
                 i, game_status, random, move_cnt, time_sec, win_flag);
      end
      if (i < 2) step(1);
    end
    rst = 1'b0;
    n = 0;
    while (game_status !== 2'b10 && n < 30) begin
      step();
      n++;
    end
    n_cmp++;
    if (n != DB + 4) begin
      n_bad++;
      $display("FAIL reset_go_latency: got %0d cycles want %0d", n, DB + 4);
    end
    btn_go = 1'b0; btn_move = 1'b0;
    wait_status(2'b01, 20);
    step(3);
    press(1'b0, 10, 10);
    n_cmp++;
    if (game_status !== 2'b00 || move_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_abort: got st=%b mv=%0d want 00/0", game_status, move_cnt);
    end
    n_cmp++;
    if (d_pulses != p0) begin
      n_bad++;
      $display("FAIL reset_no_random: got %0d pulses want 0", d_pulses - p0);
    end
    n_cmp++;
    if (mon_bad != mb0) begin
      n_bad++;
      $display("FAIL model_reset: %s", mon_msg);
    end
  endtask

  task automatic test_shuffle();
    int p0, h0, mb0;
    p0 = d_pulses; h0 = d_high; mb0 = mon_bad;
    board_out = 12'($urandom_range(1, 4095));
    for (int i = 0; i < 3; i++) press(1'b1, 10, 10);
    n_cmp++;
    if (d_pulses - p0 != 3 || d_high - h0 != 3) begin
      n_bad++;
      $display("FAIL shuffle_pulses: got %0d pulses %0d high cycles want 3/3",
               d_pulses - p0, d_high - h0);
    end
    n_cmp++;
    if (game_status !== 2'b00 || move_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL shuffle_state: got st=%b mv=%0d want 00/0", game_status, move_cnt);
    end
    n_cmp++;
    if (mon_bad != mb0) begin
      n_bad++;
      $display("FAIL model_shuffle: %s", mon_msg);
    end
  endtask

  task automatic test_start_play();
    int n10, p0, mb0;
    mb0 = mon_bad;
    board_out = 12'($urandom_range(1, 4095));
    btn_go = 1'b1;
    n10 = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (game_status === 2'b10) n10++;
      if (game_status === 2'b01) break;
    end
    n_cmp++;
    if (n10 != 2 || game_status !== 2'b01) begin
      n_bad++;
      $display("FAIL start_init: got %0d init cycles st=%b want 2/01", n10, game_status);
    end
    n_cmp++;
    if (move_cnt !== 8'd0 || time_sec !== 10'd0) begin
      n_bad++;
      $display("FAIL start_clear: got mv=%0d sec=%0d want 0/0", move_cnt, time_sec);
    end
    for (int i = 1; i <= 35; i++) begin
      step();
      if (i == 5) btn_go = 1'b0;
      if (i == 9 || i == 10 || i == 35) begin
        n_cmp++;
        if (time_sec !== 10'(i / TD)) begin
          n_bad++;
          $display("FAIL play_time@%0d: got %0d want %0d", i, time_sec, i / TD);
        end
      end
    end
    p0 = d_pulses;
    for (int i = 0; i < 5; i++)
      press(1'b1, $urandom_range(8, 14), $urandom_range(8, 14));
    n_cmp++;
    if (move_cnt !== 8'd5 || d_pulses - p0 != 5) begin
      n_bad++;
      $display("FAIL play_moves: got mv=%0d pulses=%0d want 5/5", move_cnt, d_pulses - p0);
    end
    n_cmp++;
    if (mon_bad != mb0) begin
      n_bad++;
      $display("FAIL model_play: %s", mon_msg);
    end
  endtask

  task automatic test_win();
    int mb0, p0;
    logic [7:0] mc;
    logic [9:0] ts;
    mb0 = mon_bad;
    press(1'b0, 10, 10);
    n_cmp++;
    if (game_status !== 2'b00) begin
      n_bad++;
      $display("FAIL win_abort: got st=%b want 00", game_status);
    end
    board_out = 12'h000;
    press(1'b0, 10, 10);
    wait_status(2'b01, 20);
    step(6);
    n_cmp++;
    if (game_status !== 2'b01 || win_flag !== 1'b0) begin
      n_bad++;
      $display("FAIL win_presolved: got st=%b win=%b want 01/0", game_status, win_flag);
    end
    board_out = 12'($urandom_range(1, 4095));
    press(1'b1, $urandom_range(8, 12), $urandom_range(8, 12));
    press(1'b1, $urandom_range(8, 12), $urandom_range(8, 12));
    n_cmp++;
    if (move_cnt !== 8'd2 || game_status !== 2'b01) begin
      n_bad++;
      $display("FAIL win_setup: got mv=%0d st=%b want 2/01", move_cnt, game_status);
    end
    board_out = 12'h000;
    step(1);
    n_cmp++;
    if (game_status !== 2'b11 || win_flag !== 1'b1) begin
      n_bad++;
      $display("FAIL win_detect: got st=%b win=%b want 11/1", game_status, win_flag);
    end
    mc = move_cnt; ts = time_sec; p0 = d_pulses;
    step(50);
    press(1'b1, 10, 10);
    n_cmp++;
    if (move_cnt !== mc || time_sec !== ts || d_pulses != p0 || game_status !== 2'b11) begin
      n_bad++;
      $display("FAIL win_frozen: got mv=%0d sec=%0d pulses=%0d st=%b want %0d/%0d/0/11",
               move_cnt, time_sec, d_pulses - p0, game_status, mc, ts);
    end
    press(1'b0, 10, 10);
    n_cmp++;
    if (game_status !== 2'b00 || win_flag !== 1'b0 || move_cnt !== mc) begin
      n_bad++;
      $display("FAIL win_exit: got st=%b win=%b mv=%0d want 00/0/%0d",
               game_status, win_flag, move_cnt, mc);
    end
    n_cmp++;
    if (mon_bad != mb0) begin
      n_bad++;
      $display("FAIL model_win: %s", mon_msg);
    end
  endtask

  task automatic test_bounce_priority();
    int mb0, p0;
    logic [7:0] mc;
    mb0 = mon_bad;
    board_out = 12'($urandom_range(1, 4095));
    press(1'b0, 10, 10);
    wait_status(2'b01, 20);
    press(1'b1, 10, 10);
    mc = move_cnt; p0 = d_pulses;
    for (int i = 0; i < 2; i++) begin
      btn_move = 1'b1;
      step($urandom_range(1, 2));
      btn_move = 1'b0;
      step($urandom_range(1, 2));
    end
    step(20);
    n_cmp++;
    if (d_pulses != p0 || move_cnt !== mc) begin
      n_bad++;
      $display("FAIL bounce: got pulses=%0d mv=%0d want 0/%0d", d_pulses - p0, move_cnt, mc);
    end
    btn_go = 1'b1; btn_move = 1'b1;
    wait_status(2'b00, 30);
    step(3);
    n_cmp++;
    if (game_status !== 2'b00 || d_pulses != p0 || move_cnt !== mc) begin
      n_bad++;
      $display("FAIL priority: got st=%b pulses=%0d mv=%0d want 00/0/%0d",
               game_status, d_pulses - p0, move_cnt, mc);
    end
    btn_go = 1'b0; btn_move = 1'b0;
    step(12);
    n_cmp++;
    if (mon_bad != mb0) begin
      n_bad++;
      $display("FAIL model_bounce: %s", mon_msg);
    end
  endtask

  task automatic test_saturation();
    int mb0;
    mb0 = mon_bad;
    board_out = 12'hFFF;
    press(1'b0, 10, 10);
    wait_status(2'b01, 20);
    for (int i = 0; i < 260; i++)
      press(1'b1, $urandom_range(5, 8), $urandom_range(5, 8));
    n_cmp++;
    if (move_cnt !== 8'd255 || game_status !== 2'b01) begin
      n_bad++;
      $display("FAIL sat_moves: got mv=%0d st=%b want 255/01", move_cnt, game_status);
    end
    step(1000 * TD + 20);
    n_cmp++;
    if (time_sec !== 10'd999) begin
      n_bad++;
      $display("FAIL sat_time: got %0d want 999", time_sec);
    end
    n_cmp++;
    if (mon_bad != mb0) begin
      n_bad++;
      $display("FAIL model_sat: %s", mon_msg);
    end
  endtask

  task automatic test_reset_midgame();
    int p0;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    n_cmp++;
    if ({game_status, random, move_cnt, time_sec, win_flag} !== 22'b0) begin
      n_bad++;
      $display("FAIL midreset: got st=%b rnd=%b mv=%0d sec=%0d win=%b want all 0",
               game_status, random, move_cnt, time_sec, win_flag);
    end
    p0 = d_pulses;
    step(5);
    n_cmp++;
    if (d_pulses != p0 || game_status !== 2'b00) begin
      n_bad++;
      $display("FAIL midreset_after: got pulses=%0d st=%b want 0/00", d_pulses - p0, game_status);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_shuffle();
    test_start_play();
    test_win();
    test_bounce_priority();
    test_saturation();
    test_reset_midgame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
